// File: rtl/rf_dump_uart.sv
// rf_dump_uart: walks the register file debug port from FIRST_REG to LAST_REG and
// streams each register as a 5-byte 8N1 UART frame {index, data[31:24] .. data[7:0]}.
module rf_dump_uart #(
    parameter int CLK_DIV   = 868,
    parameter int FIRST_REG = 0,
    parameter int LAST_REG  = 31
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    output logic [4:0]  reg_sel,
    input  logic [31:0] reg_data,
    output logic        txd,
    output logic        busy,
    output logic        done
);

    localparam int                BAUD_W    = $clog2(CLK_DIV);
    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLK_DIV - 1);
    localparam logic [4:0]        SEL_FIRST = 5'(FIRST_REG);
    localparam logic [4:0]        SEL_LAST  = 5'(LAST_REG);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SEL,
        S_LOAD,
        S_TX
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [BAUD_W-1:0] r_baud;
    logic [3:0]        r_bit;
    logic [2:0]        r_byte;
    logic [9:0]        r_shift;
    logic [31:0]       r_data;
    logic [4:0]        r_sel;
    logic              r_busy;
    logic              r_done;
    logic              w_bit_end;
    logic              w_stop_end;
    logic              w_last_byte;
    logic              w_last_reg;
    logic              w_txd;

    assign w_bit_end   = (r_baud == BAUD_LAST);
    assign w_stop_end  = w_bit_end && (r_bit == 4'd9);
    assign w_last_byte = (r_byte == 3'd4);
    assign w_last_reg  = (r_sel == SEL_LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_txd       = 1'b1;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_state_nxt = S_SEL;
                end
            end
            S_SEL: begin
                w_state_nxt = S_LOAD;
            end
            S_LOAD: begin
                w_state_nxt = S_TX;
            end
            S_TX: begin
                w_txd = r_shift[0];
                if (w_stop_end) begin
                    if (!w_last_byte) begin
                        w_state_nxt = S_TX;
                    end else if (!w_last_reg) begin
                        w_state_nxt = S_SEL;
                    end else begin
                        w_state_nxt = S_IDLE;
                    end
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // Byte 0 is the index, sent straight from r_sel; r_data keeps the four data
    // bytes and shifts left so the next byte to send always sits in [31:24].
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_baud  <= '0;
            r_bit   <= '0;
            r_byte  <= '0;
            r_shift <= '0;
            r_data  <= '0;
            r_sel   <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_sel  <= SEL_FIRST;
                        r_busy <= 1'b1;
                    end
                end
                S_LOAD: begin
                    r_data  <= reg_data;
                    r_shift <= {1'b1, 3'b000, r_sel, 1'b0};
                    r_byte  <= '0;
                    r_bit   <= '0;
                    r_baud  <= '0;
                end
                S_TX: begin
                    if (!w_bit_end) begin
                        r_baud <= r_baud + BAUD_W'(1);
                    end else begin
                        r_baud <= '0;
                        if (r_bit != 4'd9) begin
                            r_bit   <= r_bit + 4'd1;
                            r_shift <= {1'b1, r_shift[9:1]};
                        end else begin
                            r_bit <= '0;
                            if (!w_last_byte) begin
                                r_byte  <= r_byte + 3'd1;
                                r_shift <= {1'b1, r_data[31:24], 1'b0};
                                r_data  <= {r_data[23:0], 8'h00};
                            end else if (!w_last_reg) begin
                                r_sel <= r_sel + 5'd1;
                            end else begin
                                r_busy <= 1'b0;
                                r_done <= 1'b1;
                            end
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign reg_sel = r_sel;
    assign txd     = w_txd;
    assign busy    = r_busy;
    assign done    = r_done;

endmodule

// File: tb/tb_rf_dump_uart.sv
// Bench for rf_dump_uart: a single-register and a full-range instance, decoded by
// a behavioural 8N1 receiver and compared with frames derived from the register file.
module tb_rf_dump_uart;

    localparam int DIV       = 4;
    localparam int FRAME_CYC = 50 * DIV + 2;

    logic        clk;
    logic        rst;
    logic        start;
    logic        use_full;
    logic [31:0] rf [32];

    logic        start_s, start_f;
    logic [4:0]  sel_s, sel_f;
    logic [31:0] data_s, data_f;
    logic        txd_s, txd_f, busy_s, busy_f, done_s, done_f;
    logic        mon_txd, mon_busy, mon_done;

    int n_checks = 0;
    int n_fail   = 0;

    logic [7:0] rx_q[$];
    int         rx_err = 0;
    logic [7:0] exp_q[$];

    typedef struct {
        logic [31:0] data;
        logic [39:0] frame;
    } vec_t;
    vec_t vecs[5];

    assign start_s  = use_full ? 1'b0 : start;
    assign start_f  = use_full ? start : 1'b0;
    assign data_s   = (sel_s == 5'd0) ? 32'h0 : rf[sel_s];
    assign data_f   = (sel_f == 5'd0) ? 32'h0 : rf[sel_f];
    assign mon_txd  = use_full ? txd_f : txd_s;
    assign mon_busy = use_full ? busy_f : busy_s;
    assign mon_done = use_full ? done_f : done_s;

    rf_dump_uart #(.CLK_DIV(DIV), .FIRST_REG(5), .LAST_REG(5)) u_single (
        .clk(clk), .rst(rst), .start(start_s), .reg_sel(sel_s), .reg_data(data_s),
        .txd(txd_s), .busy(busy_s), .done(done_s)
    );

    rf_dump_uart #(.CLK_DIV(DIV), .FIRST_REG(0), .LAST_REG(31)) u_full (
        .clk(clk), .rst(rst), .start(start_f), .reg_sel(sel_f), .reg_data(data_f),
        .txd(txd_f), .busy(busy_f), .done(done_f)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // 8N1 receiver: every bit must be stable for exactly DIV samples.
    initial begin
        logic [9:0] bits;
        bit         abort;
        bit         bad;
        forever begin
            @(negedge clk);
            if (!rst && mon_txd === 1'b0) begin
                abort = 1'b0;
                bad   = 1'b0;
                bits  = '0;
                for (int k = 0; k < 10; k++) begin
                    for (int c = 0; c < DIV; c++) begin
                        if (k != 0 || c != 0) @(negedge clk);
                        if (rst) abort = 1'b1;
                        if (c == 0) bits[k] = mon_txd;
                        else if (mon_txd !== bits[k]) bad = 1'b1;
                    end
                end
                if (!abort) begin
                    if (bad || bits[0] !== 1'b0 || bits[9] !== 1'b1) rx_err++;
                    else rx_q.push_back(bits[8:1]);
                end
            end
        end
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] rf_view(input int idx);
        return (idx == 0) ? 32'h0 : rf[idx];
    endfunction

    task automatic model_dump(input int first, input int last);
        logic [31:0] v;
        for (int r = first; r <= last; r++) begin
            v = rf_view(r);
            exp_q.push_back(8'(r));
            for (int b = 3; b >= 0; b--) exp_q.push_back(v[b*8 +: 8]);
        end
    endtask

    task automatic compare_rx(input string name, input int base);
        check($sformatf("%s byte count", name), 64'(rx_q.size() - base), 64'(exp_q.size()));
        for (int i = 0; i < exp_q.size(); i++) begin
            if (base + i < rx_q.size())
                check($sformatf("%s byte %0d", name, i), 64'(rx_q[base + i]), 64'(exp_q[i]));
        end
    endtask

    task automatic run_dump(input int budget, input int spam_until, input bit restart,
                            input int poke_at, input logic [31:0] poke_val,
                            output int t_rise, output int t_fall, output int t_done,
                            output int t_rise2, output int busy_cnt, output int done_cnt);
        int stop_at;
        t_rise = -1; t_fall = -1; t_done = -1; t_rise2 = -1;
        busy_cnt = 0; done_cnt = 0; stop_at = budget;
        start = 1'b1;
        for (int c = 1; c <= budget; c++) begin
            @(negedge clk);
            start = 1'b0;
            if (spam_until > 0 && c >= 4 && c <= spam_until && (c % 7) == 0) start = 1'b1;
            if (c == poke_at) rf[5] = poke_val;
            if (mon_busy) busy_cnt++;
            if (mon_busy && t_rise < 0) t_rise = c;
            if (t_done >= 0 && c > t_done && mon_busy && t_rise2 < 0) t_rise2 = c;
            if (!mon_txd && t_fall < 0) t_fall = c;
            if (mon_done) begin
                done_cnt++;
                if (t_done < 0) begin
                    t_done = c;
                    if (restart) start = 1'b1;
                end
                if (!restart || done_cnt >= 2) stop_at = c + 4;
            end
            if (c >= stop_at) break;
        end
        start = 1'b0;
        check("dump completed within budget", 64'(t_done >= 0), 64'd1);
    endtask

    initial begin
        int tr, tf, td, tr2, bc, dc, base, err0, nbusy, ndone;
        start = 1'b0;
        use_full = 1'b0;
        rst = 1'b0;
        for (int i = 0; i < 32; i++) rf[i] = '0;
        vecs[0] = '{32'hDEADBEEF, 40'h05DEADBEEF};
        vecs[1] = '{32'h00000000, 40'h0500000000};
        vecs[2] = '{32'hFFFFFFFF, 40'h05FFFFFFFF};
        vecs[3] = '{32'h12345678, 40'h0512345678};
        vecs[4] = '{32'h80000001, 40'h0580000001};

        // asynchronous reset before any clock edge
        #1 rst = 1'b1;
        #1;
        check("reset txd_s", 64'(txd_s), 64'd1);
        check("reset busy_s", 64'(busy_s), 64'd0);
        check("reset done_s", 64'(done_s), 64'd0);
        check("reset sel_s", 64'(sel_s), 64'd0);
        check("reset txd_f", 64'(txd_f), 64'd1);
        check("reset busy_f", 64'(busy_f), 64'd0);
        check("reset sel_f", 64'(sel_f), 64'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // single-register frames from the vector table
        for (int v = 0; v < 5; v++) begin
            rf[5] = vecs[v].data;
            base = rx_q.size();
            err0 = rx_err;
            run_dump(400, 0, 1'b0, -1, 32'h0, tr, tf, td, tr2, bc, dc);
            check($sformatf("v%0d busy rise", v), 64'(tr), 64'd1);
            check($sformatf("v%0d start bit delay", v), 64'(tf - tr), 64'd2);
            check($sformatf("v%0d done delay", v), 64'(td - tr), 64'(FRAME_CYC));
            check($sformatf("v%0d busy length", v), 64'(bc), 64'(FRAME_CYC));
            check($sformatf("v%0d done pulses", v), 64'(dc), 64'd1);
            check($sformatf("v%0d framing errors", v), 64'(rx_err - err0), 64'd0);
            check($sformatf("v%0d byte count", v), 64'(rx_q.size() - base), 64'd5);
            for (int b = 0; b < 5; b++) begin
                if (base + b < rx_q.size())
                    check($sformatf("v%0d byte %0d", v, b), 64'(rx_q[base + b]),
                          64'(vecs[v].frame[(4 - b)*8 +: 8]));
            end
            check($sformatf("v%0d reg_sel hold", v), 64'(sel_s), 64'd5);
        end

        // full walk: directed pattern then randomised contents
        use_full = 1'b1;
        repeat (4) @(negedge clk);
        for (int round = 0; round < 2; round++) begin
            for (int i = 0; i < 32; i++) rf[i] = (round == 0) ? 32'(i) * 32'h01010101 : $urandom;
            exp_q.delete();
            model_dump(0, 31);
            base = rx_q.size();
            err0 = rx_err;
            run_dump(7000, 0, 1'b0, -1, 32'h0, tr, tf, td, tr2, bc, dc);
            check($sformatf("full%0d start bit delay", round), 64'(tf - tr), 64'd2);
            check($sformatf("full%0d done delay", round), 64'(td - tr), 64'(32 * FRAME_CYC));
            check($sformatf("full%0d busy length", round), 64'(bc), 64'(32 * FRAME_CYC));
            check($sformatf("full%0d done pulses", round), 64'(dc), 64'd1);
            check($sformatf("full%0d framing errors", round), 64'(rx_err - err0), 64'd0);
            compare_rx($sformatf("full%0d", round), base);
            check($sformatf("full%0d reg_sel hold", round), 64'(sel_f), 64'd31);
            if (round == 0 && rx_q.size() >= base + 160) begin
                check("full0 frame0 data", 64'({rx_q[base+1], rx_q[base+2], rx_q[base+3], rx_q[base+4]}), 64'h0);
                check("full0 frame31", 64'({rx_q[base+155], rx_q[base+156], rx_q[base+157],
                                             rx_q[base+158], rx_q[base+159]}), 64'h1F1F1F1F1F);
            end
        end

        // start spam while busy, then a restart in the done cycle
        use_full = 1'b0;
        repeat (4) @(negedge clk);
        rf[5] = $urandom;
        exp_q.delete();
        model_dump(5, 5);
        model_dump(5, 5);
        base = rx_q.size();
        err0 = rx_err;
        run_dump(800, 150, 1'b1, -1, 32'h0, tr, tf, td, tr2, bc, dc);
        check("spam done delay", 64'(td - tr), 64'(FRAME_CYC));
        check("spam done pulses (two dumps)", 64'(dc), 64'd2);
        check("restart busy delay after done", 64'(tr2 - td), 64'd1);
        check("spam framing errors", 64'(rx_err - err0), 64'd0);
        compare_rx("spam", base);

        // snapshot: register changes during byte 2 must not reach the line
        repeat (4) @(negedge clk);
        rf[5] = 32'h13579BDF;
        exp_q.delete();
        model_dump(5, 5);
        base = rx_q.size();
        run_dump(400, 0, 1'b0, 95, 32'hECA86420, tr, tf, td, tr2, bc, dc);
        compare_rx("snapshot", base);

        // reset during data bit 3 of byte 1
        repeat (4) @(negedge clk);
        rf[5] = 32'h00112233;
        start = 1'b1;
        ndone = 0;
        for (int c = 1; c <= 60; c++) begin
            @(negedge clk);
            start = 1'b0;
            if (done_s) ndone++;
        end
        check("pre-reset txd low in byte1 bit3", 64'(txd_s), 64'd0);
        check("pre-reset busy", 64'(busy_s), 64'd1);
        rst = 1'b1;
        #1;
        check("midreset txd", 64'(txd_s), 64'd1);
        check("midreset busy", 64'(busy_s), 64'd0);
        check("midreset done", 64'(done_s), 64'd0);
        check("midreset reg_sel", 64'(sel_s), 64'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        nbusy = 0;
        for (int c = 0; c < 60; c++) begin
            @(negedge clk);
            if (done_s) ndone++;
            if (busy_s) nbusy++;
        end
        check("no done after reset", 64'(ndone), 64'd0);
        check("idle after reset", 64'(nbusy), 64'd0);
        exp_q.delete();
        model_dump(5, 5);
        base = rx_q.size();
        err0 = rx_err;
        run_dump(400, 0, 1'b0, -1, 32'h0, tr, tf, td, tr2, bc, dc);
        check("post-reset done delay", 64'(td - tr), 64'(FRAME_CYC));
        check("post-reset done pulses", 64'(dc), 64'd1);
        check("post-reset framing errors", 64'(rx_err - err0), 64'd0);
        compare_rx("post-reset", base);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
